// File: rtl/dpb_packer_if.sv
// dpb_packer_if: byte-in / word-out handshake bundle for the PDP-10 byte deposit engine
interface dpb_packer_if;
    logic        start;
    logic [0:5]  size;
    logic [0:35] byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic [0:35] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [0:5]  pos;
    logic        size_err;

    modport master (
        output start, size, byte_in, byte_valid, flush, word_ready,
        input  byte_ready, word_out, word_valid, pos, size_err
    );

    modport slave (
        input  start, size, byte_in, byte_valid, flush, word_ready,
        output byte_ready, word_out, word_valid, pos, size_err
    );
endinterface

// File: rtl/dpb_packer.sv
// dpb_packer: deposits right-justified S-bit bytes left to right into 36-bit words (P <- P - S)
module dpb_packer (
    input logic          clk,
    input logic          rst,
    input logic          clken_i,
    dpb_packer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t      state_q, state_d;
    logic [0:5]  sz_q, sz_d, p_q, p_d, p_n;
    logic [0:35] acc_q, acc_d, acc_n, word_q, word_d, mask;
    logic        err_q, err_d, accept, legal, done;

    // sz=36 wraps the shifted one to zero, so the subtraction yields an all-ones mask
    assign mask   = (36'd1 << sz_q) - 36'd1;
    assign accept = (state_q == FILL) && bus.byte_valid;
    assign legal  = (bus.size != 6'd0) && (bus.size <= 6'd36);
    assign p_n    = accept ? p_q - sz_q : p_q;
    assign acc_n  = accept ? acc_q | ((bus.byte_in & mask) << p_n) : acc_q;
    assign done   = (accept && p_n < sz_q) || (bus.flush && p_n != 6'd36);

    // State register; reset wins over clken
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sz_q    <= 6'd0;
            p_q     <= 6'd36;
            acc_q   <= 36'd0;
            word_q  <= 36'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sz_q    <= sz_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Next state: start has priority, then fill/flush or the emit handshake
    always_comb begin
        state_d = state_q;
        sz_d    = sz_q;
        p_d     = p_q;
        acc_d   = acc_q;
        word_d  = word_q;
        err_d   = 1'b0;
        if (clken_i) begin
            if (bus.start) begin
                if (legal) begin
                    sz_d    = bus.size;
                    p_d     = 6'd36;
                    acc_d   = 36'd0;
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end else if (state_q == FILL) begin
                if (done) begin
                    word_d  = acc_n;
                    acc_d   = 36'd0;
                    p_d     = 6'd36;
                    state_d = EMIT;
                end else begin
                    acc_d = acc_n;
                    p_d   = p_n;
                end
            end else if (state_q == EMIT && bus.word_ready) begin
                state_d = FILL;
            end
        end
    end

    assign bus.byte_ready = (state_q == FILL);
    assign bus.word_valid = (state_q == EMIT);
    assign bus.word_out   = word_q;
    assign bus.pos        = p_q;
    assign bus.size_err   = err_q;
endmodule

// File: tb/tb_dpb_packer.sv
// tb_dpb_packer: directed vectors, expected words queued and checked by an independent monitor
module tb_dpb_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clken = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [35:0] exp_q[$];

    dpb_packer_if bus();

    dpb_packer dut (.clk(clk), .rst(rst), .clken_i(clken), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0o exp=%0o", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] s);
        bus.start = 1'b1;
        bus.size  = s;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [35:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    // Monitor: every completed word handshake pops the next expected word
    always @(negedge clk) begin
        if (rst && clken && bus.word_valid && bus.word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word unexpected got=%0o exp=none", bus.word_out);
            end else begin
                chk("word", bus.word_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [35:0] b7 [5];
        logic [35:0] b12 [3];
        b7  = '{36'o101, 36'o102, 36'o103, 36'o104, 36'o105};
        b12 = '{36'o7777, 36'o0001, 36'o1234};
        bus.start = 1'b0;
        bus.size = 6'd0;
        bus.byte_in = 36'd0;
        bus.byte_valid = 1'b0;
        bus.flush = 1'b0;
        bus.word_ready = 1'b1;
        tick();
        tick();
        chk("rst_wvalid", 36'(bus.word_valid), 36'd0);
        chk("rst_bready", 36'(bus.byte_ready), 36'd0);
        chk("rst_pos", 36'(bus.pos), 36'd36);
        chk("rst_wout", bus.word_out, 36'd0);
        chk("rst_err", 36'(bus.size_err), 36'd0);
        rst = 1'b1;
        tick();

        // size 7, five bytes back to back
        do_start(6'd7);
        chk("s7_pos0", 36'(bus.pos), 36'd36);
        chk("s7_bready", 36'(bus.byte_ready), 36'd1);
        exp_q.push_back(36'o406050342212);
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.byte_in = b7[i];
            tick();
            chk("s7_pos", 36'(bus.pos), (i == 4) ? 36'd36 : 36'(36 - 7 * (i + 1)));
        end
        bus.byte_valid = 1'b0;
        chk("s7_wvalid", 36'(bus.word_valid), 36'd1);
        chk("s7_bready_emit", 36'(bus.byte_ready), 36'd0);
        tick();
        chk("s7_back_fill", 36'(bus.byte_ready), 36'd1);

        // size 36 with a five-cycle consumer stall
        do_start(6'd36);
        bus.word_ready = 1'b0;
        exp_q.push_back(36'o123456701234);
        send(36'o123456701234);
        chk("s36_wvalid", 36'(bus.word_valid), 36'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s36_stall_valid", 36'(bus.word_valid), 36'd1);
            chk("s36_stall_word", bus.word_out, 36'o123456701234);
            chk("s36_stall_bready", 36'(bus.byte_ready), 36'd0);
        end
        bus.word_ready = 1'b1;
        tick();
        chk("s36_release", 36'(bus.byte_ready), 36'd1);

        // size 8, two bytes then flush; then flush on empty word
        do_start(6'd8);
        exp_q.push_back(36'o776004000000);
        send(36'o377);
        send(36'o001);
        chk("s8_pos", 36'(bus.pos), 36'd20);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("s8_flush_valid", 36'(bus.word_valid), 36'd1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("s8_empty_flush", 36'(bus.word_valid), 36'd0);
        chk("s8_empty_pos", 36'(bus.pos), 36'd36);

        // size 6, byte and flush together
        do_start(6'd6);
        exp_q.push_back(36'o770000000000);
        bus.flush = 1'b1;
        send(36'o77);
        bus.flush = 1'b0;
        chk("s6_bf_valid", 36'(bus.word_valid), 36'd1);
        tick();
        chk("s6_bf_once", 36'(bus.word_valid), 36'd0);

        // illegal sizes
        do_start(6'd0);
        chk("err0_pulse", 36'(bus.size_err), 36'd1);
        chk("err0_bready", 36'(bus.byte_ready), 36'd0);
        tick();
        chk("err0_clear", 36'(bus.size_err), 36'd0);
        do_start(6'd37);
        chk("err37_pulse", 36'(bus.size_err), 36'd1);
        chk("err37_bready", 36'(bus.byte_ready), 36'd0);
        tick();
        chk("err37_clear", 36'(bus.size_err), 36'd0);

        // restart mid-word discards partial data
        do_start(6'd6);
        send(36'o77);
        send(36'o77);
        do_start(6'd6);
        chk("restart_pos", 36'(bus.pos), 36'd36);
        exp_q.push_back(36'o010101010101);
        for (int i = 0; i < 6; i++) send(36'o01);
        tick();

        // clken gating during a size 12 fill
        do_start(6'd12);
        exp_q.push_back(36'o777700011234);
        for (int i = 0; i < 3; i++) begin
            logic [5:0] p0;
            p0 = bus.pos;
            bus.byte_valid = 1'b1;
            bus.byte_in = b12[i];
            clken = 1'b0;
            tick();
            chk("ce_hold_pos", 36'(bus.pos), 36'(p0));
            clken = 1'b1;
            tick();
        end
        bus.byte_valid = 1'b0;
        clken = 1'b0;
        tick();
        chk("ce_hold_emit", 36'(bus.word_valid), 36'd1);
        clken = 1'b1;
        tick();
        chk("ce_done", 36'(bus.word_valid), 36'd0);

        // reset during EMIT
        do_start(6'd36);
        bus.word_ready = 1'b0;
        send(36'o555555555555);
        chk("rstemit_pre", 36'(bus.word_valid), 36'd1);
        rst = 1'b0;
        tick();
        chk("rstemit_wvalid", 36'(bus.word_valid), 36'd0);
        chk("rstemit_bready", 36'(bus.byte_ready), 36'd0);
        chk("rstemit_pos", 36'(bus.pos), 36'd36);
        chk("rstemit_wout", bus.word_out, 36'd0);
        rst = 1'b1;
        bus.word_ready = 1'b1;
        tick();

        chk("queue_empty", 36'(exp_q.size()), 36'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
